obi_delay_memory: RTL and testbench
===================================

OBI_DELAY_MEMORY -- requirements
Module: obi_delay_memory

Interface
REQ-001 SHALL have parameter NumWords, default 128, memory depth in words (2..4096).
REQ-002 SHALL have parameter DataWidth, default 32, word width in bits (multiple of 8, 8..64).
REQ-003 SHALL have parameter GntLatency, default 1, cycles req_i held before gnt_o (0..7).
REQ-004 SHALL have parameter RspLatency, default 2, cycles from grant to rvalid_o (1..15).
REQ-005 SHALL have parameter MaxOutstanding, default 4, granted-but-unanswered transaction limit (power of 2, 1..16).
REQ-006 SHALL have port clk_i  input  1  the block's one clock; all state on rising edge.
REQ-007 SHALL have port rst_i  input  1  reset, asynchronous, active-high.
REQ-008 SHALL have port req_i  input  1  OBI request valid.
REQ-009 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-010 SHALL have port addr_i  input  AW=$clog2(NumWords)  word address.
REQ-011 SHALL have port wdata_i  input  DataWidth  write data.
REQ-012 SHALL have port be_i  input  DataWidth/8  byte enables.
REQ-013 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-014 SHALL have port rvalid_o  output  1  response valid.
REQ-015 SHALL have port rdata_o  output  DataWidth  read data; 0 when rvalid_o low or write response.
REQ-016 SHALL have port outstanding_o  output  $clog2(MaxOutstanding)+1  pending response count.

Function
REQ-017 Grant FSM SHALL have states IDLE, WAIT, GRANT; IDLE->WAIT on req_i; WAIT counts cycles with req_i high; WAIT->GRANT when count reaches GntLatency-1 (GntLatency=0: GRANT directly from IDLE, gnt_o combinational on req_i).
REQ-018 gnt_o SHALL be asserted only in GRANT with req_i high and outstanding_o < MaxOutstanding; GRANT stays until handshake, then ->IDLE (or ->WAIT if req_i stays high and GntLatency>0).
REQ-019 req_i falling before gnt_o (protocol violation) SHALL return FSM to IDLE and clear the wait count.
REQ-020 On req_i&&gnt_o with we_i=1, the bytes selected by be_i SHALL be written in that cycle; be_i=0 writes nothing but still produces a response.
REQ-021 On req_i&&gnt_o with we_i=0, read data SHALL be sampled in that cycle (pre-write value of any same-cycle write is impossible, one port).
REQ-022 Each granted transaction SHALL produce exactly one single-cycle rvalid_o pulse RspLatency cycles after grant, in grant order.
REQ-023 Back-to-back grants SHALL yield back-to-back rvalid_o pulses; push and pop in the same cycle SHALL leave outstanding_o unchanged.
REQ-024 outstanding_o = MaxOutstanding SHALL block gnt_o; a same-cycle response pop SHALL NOT free the slot until the next cycle.
REQ-025 addr_i >= NumWords SHALL be granted normally; writes discarded, reads return 0.

Reset
REQ-026 rst_i SHALL force gnt_o=0, rvalid_o=0, rdata_o=0, outstanding_o=0, FSM=IDLE, wait count=0, LFSR=seed, asynchronously.
REQ-027 Reset mid-operation SHALL drop all pending responses; no rvalid_o for them after release.
REQ-028 Memory array contents SHALL NOT be reset.

Configuration
REQ-029 Macro OBI_DELAY_MEMORY_LFSR_STALL_EN defined: effective grant wait SHALL be GntLatency + LFSR[2:0] (16-bit Fibonacci LFSR, advanced once per handshake), re-drawn per transaction.
REQ-030 Macro undefined: grant wait SHALL be exactly GntLatency; no LFSR logic synthesised.

Structure
REQ-031 Package obi_delay_memory_pkg SHALL hold the FSM state enum, LFSR seed 16'hACE1, LFSR taps, and latency-counter width constants.
REQ-032 Response queue SHALL be sub-module obi_delay_memory_rsp_fifo (entries: rdata, we flag, countdown), depth MaxOutstanding.

Verification
REQ-033 Defaults, write 0xDEADBEEF to addr 5 be=4'hF, then read addr 5 -> gnt 1 cycle after req, rvalid 2 cycles after each grant, rdata=0xDEADBEEF.
REQ-034 Write 0x11223344 then be=4'b0010 write 0xFFFFFFFF to same addr, read -> rdata=0x1122FF44.
REQ-035 MaxOutstanding=2, RspLatency=8, GntLatency=0, req held 6 cycles -> exactly 2 grants, third gnt only the cycle after first rvalid.
REQ-036 Assert rst_i with 3 responses pending -> all outputs 0 immediately, zero rvalid pulses after release, memory data retained.
REQ-037 NumWords=100, read addr 120 -> granted, rvalid with rdata=0; write addr 120 then read addr 20 -> unchanged.
REQ-038 With OBI_DELAY_MEMORY_LFSR_STALL_EN, 64 reads -> every grant wait in [GntLatency, GntLatency+7], sequence identical across two runs.

Source files
------------

// File: rtl/obi_delay_memory_pkg.sv
// Shared types and constants for obi_delay_memory: grant FSM states, stall LFSR, counter widths.
// No logic here; the LFSR step helper is used only by builds with random grant stalls.
package obi_delay_memory_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_GRANT
    } gnt_state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16 + x^14 + x^13 + x^11, expressed as the bits XORed into the new MSB
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    // Wait counter must hold GntLatency (7) plus the largest random stall (7)
    localparam int unsigned GNT_CNT_W = 4;
    localparam int unsigned RSP_CNT_W = 4;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/obi_delay_memory_rsp_fifo.sv
// In-order response queue: each entry carries read data, write flag and a countdown to its rvalid.
// Latency: an entry pushed in cycle t pops in cycle t+RspLatency; push is never offered when full.
// Backpressure: none downstream; the pop is unconditional once the head countdown expires.
module obi_delay_memory_rsp_fifo
    import obi_delay_memory_pkg::*;
#(
    parameter int unsigned DataWidth  = 32,
    parameter int unsigned Depth      = 4,
    parameter int unsigned RspLatency = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push_vld,
    input  logic                    push_we,
    input  logic [DataWidth-1:0]    push_dat,
    output logic                    pop_vld,
    output logic [DataWidth-1:0]    pop_dat,
    output logic [$clog2(Depth):0]  count
);

    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth) + 1;

    typedef struct packed {
        logic [DataWidth-1:0]   rdata;
        logic                   we;
        logic [RSP_CNT_W-1:0]   countdown;
    } rsp_entry_t;

    rsp_entry_t     slot_q [Depth];
    rsp_entry_t     head;
    logic [PW-1:0]  wr_ptr_q;
    logic [PW-1:0]  rd_ptr_q;
    logic [CW-1:0]  count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + PW'(1);
    endfunction

    assign head    = slot_q[rd_ptr_q];
    assign pop_vld = (count_q != '0) && (head.countdown == '0);
    assign pop_dat = (pop_vld && !head.we) ? head.rdata : '0;
    assign count   = count_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_vld) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_vld)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(push_vld) - CW'(pop_vld);
        end
    end

    // Every slot ticks down; stale slots are harmless since only the head is examined
    always_ff @(posedge clk) begin
        for (int i = 0; i < int'(Depth); i++) begin
            if (push_vld && (wr_ptr_q == PW'(i))) begin
                slot_q[i] <= '{rdata: push_dat, we: push_we, countdown: RSP_CNT_W'(RspLatency - 1)};
            end else if (slot_q[i].countdown != '0) begin
                slot_q[i].countdown <= slot_q[i].countdown - RSP_CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/obi_delay_memory.sv
// OBI slave memory model with programmable grant/response delay; OBI_DELAY_MEMORY_LFSR_STALL_EN adds random grant stalls.
// Latency: gnt_o GntLatency cycles after req_i rises (0 = combinational), rvalid_o RspLatency cycles after grant.
// Backpressure: gnt_o withheld while MaxOutstanding responses are pending; responses themselves cannot stall.
module obi_delay_memory
    import obi_delay_memory_pkg::*;
#(
    parameter int unsigned NumWords       = 128,
    parameter int unsigned DataWidth      = 32,
    parameter int unsigned GntLatency     = 1,
    parameter int unsigned RspLatency     = 2,
    parameter int unsigned MaxOutstanding = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_i,
    input  logic                                we_i,
    input  logic [$clog2(NumWords)-1:0]         addr_i,
    input  logic [DataWidth-1:0]                wdata_i,
    input  logic [DataWidth/8-1:0]              be_i,
    output logic                                gnt_o,
    output logic                                rvalid_o,
    output logic [DataWidth-1:0]                rdata_o,
    output logic [$clog2(MaxOutstanding):0]     outstanding_o
);

    localparam int unsigned AW = $clog2(NumWords);
    localparam int unsigned OW = $clog2(MaxOutstanding) + 1;
    localparam logic [AW:0]   NUM_WORDS_W = (AW + 1)'(NumWords);
    localparam logic [OW-1:0] MAX_OUT_W   = OW'(MaxOutstanding);

    gnt_state_e             state_q;
    gnt_state_e             state_d;
    logic [GNT_CNT_W-1:0]   cnt_q;
    logic [GNT_CNT_W-1:0]   cnt_d;
    logic [GNT_CNT_W-1:0]   eff_lat;
    logic [GNT_CNT_W-1:0]   eff_lat_nxt;
    logic                   hs;
    logic                   full;
    logic                   addr_ok;
    logic [DataWidth-1:0]   rd_word;
    logic [DataWidth-1:0]   mem_q [NumWords];

    assign hs   = req_i && gnt_o;
    assign full = (outstanding_o == MAX_OUT_W);

`ifdef OBI_DELAY_MEMORY_LFSR_STALL_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d      = hs ? lfsr_step(lfsr_q) : lfsr_q;
    assign eff_lat     = GNT_CNT_W'(GntLatency) + GNT_CNT_W'(lfsr_q[2:0]);
    assign eff_lat_nxt = GNT_CNT_W'(GntLatency) + GNT_CNT_W'(lfsr_d[2:0]);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= LFSR_SEED;
        else       lfsr_q <= lfsr_d;
    end
`else
    assign eff_lat     = GNT_CNT_W'(GntLatency);
    assign eff_lat_nxt = eff_lat;
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // The IDLE cycle with req_i high counts as the first wait cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!req_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (hs) begin
            state_d = (eff_lat_nxt != '0) ? ST_WAIT : ST_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (eff_lat <= GNT_CNT_W'(1)) begin
                        state_d = ST_GRANT;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = GNT_CNT_W'(1);
                    end
                end
                ST_WAIT: begin
                    if (cnt_q == eff_lat - GNT_CNT_W'(1)) begin
                        state_d = ST_GRANT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + GNT_CNT_W'(1);
                    end
                end
                ST_GRANT: state_d = ST_GRANT;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        gnt_o = 1'b0;
        if (!rst_i && req_i && !full) begin
            gnt_o = (state_q == ST_GRANT) || ((state_q == ST_IDLE) && (eff_lat == '0));
        end
    end

    assign addr_ok = ({1'b0, addr_i} < NUM_WORDS_W);
    assign rd_word = addr_ok ? mem_q[addr_i] : '0;

    always_ff @(posedge clk_i) begin
        if (hs && we_i && addr_ok) begin
            for (int b = 0; b < int'(DataWidth / 8); b++) begin
                if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    obi_delay_memory_rsp_fifo #(
        .DataWidth  (DataWidth),
        .Depth      (MaxOutstanding),
        .RspLatency (RspLatency)
    ) u_rsp_fifo (
        .clk      (clk_i),
        .rst      (rst_i),
        .push_vld (hs),
        .push_we  (we_i),
        .push_dat (rd_word),
        .pop_vld  (rvalid_o),
        .pop_dat  (rdata_o),
        .count    (outstanding_o)
    );

endmodule

// File: tb/tb_obi_delay_memory.sv
// Directed bench for obi_delay_memory: four instances cover defaults, NumWords=100,
// a saturating fast-grant configuration and a deep-queue configuration for reset.
module tb_obi_delay_memory;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fails  = 0;

    // bus d drives u_def and u_small, bus f drives u_fast and u_rst
    logic        d_req = 1'b0, d_we = 1'b0;
    logic [6:0]  d_addr = '0;
    logic [31:0] d_wdata = '0;
    logic [3:0]  d_be = '0;
    logic        f_req = 1'b0, f_we = 1'b0;
    logic [6:0]  f_addr = '0;
    logic [31:0] f_wdata = '0;
    logic [3:0]  f_be = '0;

    logic d_gnt, d_rvalid, s_gnt, s_rvalid, f_gnt, f_rvalid, r_gnt, r_rvalid;
    logic [31:0] d_rdata, s_rdata, f_rdata, r_rdata;
    logic [2:0]  d_outstanding, s_outstanding, r_outstanding;
    logic [1:0]  f_outstanding;

    obi_delay_memory u_def (
        .clk_i(clk), .rst_i(rst), .req_i(d_req), .we_i(d_we), .addr_i(d_addr), .wdata_i(d_wdata),
        .be_i(d_be), .gnt_o(d_gnt), .rvalid_o(d_rvalid), .rdata_o(d_rdata), .outstanding_o(d_outstanding));

    obi_delay_memory #(.NumWords(100)) u_small (
        .clk_i(clk), .rst_i(rst), .req_i(d_req), .we_i(d_we), .addr_i(d_addr), .wdata_i(d_wdata),
        .be_i(d_be), .gnt_o(s_gnt), .rvalid_o(s_rvalid), .rdata_o(s_rdata), .outstanding_o(s_outstanding));

    obi_delay_memory #(.MaxOutstanding(2), .RspLatency(8), .GntLatency(0)) u_fast (
        .clk_i(clk), .rst_i(rst), .req_i(f_req), .we_i(f_we), .addr_i(f_addr), .wdata_i(f_wdata),
        .be_i(f_be), .gnt_o(f_gnt), .rvalid_o(f_rvalid), .rdata_o(f_rdata), .outstanding_o(f_outstanding));

    obi_delay_memory #(.MaxOutstanding(4), .RspLatency(8), .GntLatency(0)) u_rst (
        .clk_i(clk), .rst_i(rst), .req_i(f_req), .we_i(f_we), .addr_i(f_addr), .wdata_i(f_wdata),
        .be_i(f_be), .gnt_o(r_gnt), .rvalid_o(r_rvalid), .rdata_o(r_rdata), .outstanding_o(r_outstanding));

    function automatic logic obs_gnt(input int which);
        case (which)
            0: return d_gnt;
            1: return s_gnt;
            2: return f_gnt;
            default: return r_gnt;
        endcase
    endfunction

    function automatic logic obs_rvalid(input int which);
        case (which)
            0: return d_rvalid;
            1: return s_rvalid;
            2: return f_rvalid;
            default: return r_rvalid;
        endcase
    endfunction

    function automatic logic [31:0] obs_rdata(input int which);
        case (which)
            0: return d_rdata;
            1: return s_rdata;
            2: return f_rdata;
            default: return r_rdata;
        endcase
    endfunction

    task automatic drive(input int bus, input logic req, input logic we, input logic [6:0] addr,
                         input logic [31:0] wdata, input logic [3:0] be);
        if (bus == 0) begin
            d_req = req; d_we = we; d_addr = addr; d_wdata = wdata; d_be = be;
        end else begin
            f_req = req; f_we = we; f_addr = addr; f_wdata = wdata; f_be = be;
        end
    endtask

    // One OBI transaction; gnt_wait counts cycles from req rising, rsp_wait cycles after the grant
    task automatic txn(input int bus, input int which, input logic we, input logic [6:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be,
                       output int gnt_wait, output int rsp_wait, output logic [31:0] rdata);
        logic got;
        got = 1'b0; gnt_wait = 0; rsp_wait = 0; rdata = '0;
        @(posedge clk); #1;
        drive(bus, 1'b1, we, addr, wdata, be);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (obs_gnt(which)) begin got = 1'b1; break; end
            gnt_wait++;
        end
        if (!got) begin n_checks++; n_fails++; $display("FAIL txn_gnt_timeout: got no gnt in 40 cycles, required a grant"); end
        @(posedge clk); #1;
        drive(bus, 1'b0, 1'b0, '0, '0, '0);
        for (int r = 1; r <= 40; r++) begin
            @(negedge clk);
            if (obs_rvalid(which)) begin rsp_wait = r; rdata = obs_rdata(which); break; end
        end
        if (rsp_wait == 0) begin n_checks++; n_fails++; $display("FAIL txn_rsp_timeout: got no rvalid in 40 cycles, required one"); end
    endtask

    task automatic test_reset();
        rst = 1'b1; f_req = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (d_gnt !== 1'b0)          begin n_fails++; $display("FAIL reset_gnt: got %b required 0", d_gnt); end
        n_checks++; if (d_rvalid !== 1'b0)       begin n_fails++; $display("FAIL reset_rvalid: got %b required 0", d_rvalid); end
        n_checks++; if (d_rdata !== 32'h0)       begin n_fails++; $display("FAIL reset_rdata: got %h required 0", d_rdata); end
        n_checks++; if (d_outstanding !== 3'd0)  begin n_fails++; $display("FAIL reset_outstanding: got %0d required 0", d_outstanding); end
        n_checks++; if (s_outstanding !== 3'd0)  begin n_fails++; $display("FAIL reset_small_outstanding: got %0d required 0", s_outstanding); end
        n_checks++; if (f_gnt !== 1'b0)          begin n_fails++; $display("FAIL reset_comb_gnt: got %b required 0", f_gnt); end
        n_checks++; if (f_outstanding !== 2'd0)  begin n_fails++; $display("FAIL reset_fast_outstanding: got %0d required 0", f_outstanding); end
        n_checks++; if (r_outstanding !== 3'd0)  begin n_fails++; $display("FAIL reset_rst_outstanding: got %0d required 0", r_outstanding); end
        f_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

`ifdef OBI_DELAY_MEMORY_LFSR_STALL_EN
    task automatic test_lfsr();
        int run_a [64];
        int gw, rw, distinct;
        logic [31:0] rd;
        distinct = 0;
        for (int run = 0; run < 2; run++) begin
            if (run == 1) begin
                @(negedge clk); rst = 1'b1;
                @(negedge clk); rst = 1'b0;
            end
            for (int i = 0; i < 64; i++) begin
                txn(0, 0, 1'b0, 7'(i), 32'h0, 4'h0, gw, rw, rd);
                if (run == 0) begin
                    run_a[i] = gw;
                    if (i > 0 && gw != run_a[0]) distinct++;
                    n_checks++; if (gw < 1 || gw > 8) begin n_fails++; $display("FAIL lfsr_wait_range[%0d]: got %0d required 1..8", i, gw); end
                end else begin
                    n_checks++; if (gw != run_a[i]) begin n_fails++; $display("FAIL lfsr_repeat[%0d]: got %0d required %0d", i, gw, run_a[i]); end
                end
            end
        end
        n_checks++; if (distinct == 0) begin n_fails++; $display("FAIL lfsr_variation: got constant wait %0d required variation", run_a[0]); end
    endtask
`else
    task automatic test_write_read();
        int gw, rw;
        logic [31:0] rd;
        txn(0, 0, 1'b1, 7'd5, 32'hDEADBEEF, 4'hF, gw, rw, rd);
        n_checks++; if (gw != 1)       begin n_fails++; $display("FAIL wr_gnt_wait: got %0d required 1", gw); end
        n_checks++; if (rw != 2)       begin n_fails++; $display("FAIL wr_rsp_wait: got %0d required 2", rw); end
        n_checks++; if (rd !== 32'h0)  begin n_fails++; $display("FAIL wr_rdata: got %h required 0", rd); end
        txn(0, 0, 1'b0, 7'd5, 32'h0, 4'h0, gw, rw, rd);
        n_checks++; if (gw != 1)       begin n_fails++; $display("FAIL rd_gnt_wait: got %0d required 1", gw); end
        n_checks++; if (rw != 2)       begin n_fails++; $display("FAIL rd_rsp_wait: got %0d required 2", rw); end
        n_checks++; if (rd !== 32'hDEADBEEF) begin n_fails++; $display("FAIL rd_rdata: got %h required deadbeef", rd); end
    endtask

    task automatic test_byte_enable();
        int gw, rw;
        logic [31:0] rd;
        txn(0, 0, 1'b1, 7'd9, 32'h11223344, 4'hF, gw, rw, rd);
        txn(0, 0, 1'b1, 7'd9, 32'hFFFFFFFF, 4'b0010, gw, rw, rd);
        txn(0, 0, 1'b0, 7'd9, 32'h0, 4'h0, gw, rw, rd);
        n_checks++; if (rd !== 32'h1122FF44) begin n_fails++; $display("FAIL be_merge: got %h required 1122ff44", rd); end
        txn(0, 0, 1'b1, 7'd9, 32'h0, 4'h0, gw, rw, rd);
        n_checks++; if (rw != 2)       begin n_fails++; $display("FAIL be_zero_rsp: got %0d required 2", rw); end
        txn(0, 0, 1'b0, 7'd9, 32'h0, 4'h0, gw, rw, rd);
        n_checks++; if (rd !== 32'h1122FF44) begin n_fails++; $display("FAIL be_zero_nowrite: got %h required 1122ff44", rd); end
    endtask

    task automatic test_out_of_range();
        int gw, rw;
        logic [31:0] rd;
        txn(0, 1, 1'b1, 7'd20, 32'h0BADF00D, 4'hF, gw, rw, rd);
        txn(0, 1, 1'b0, 7'd120, 32'h0, 4'h0, gw, rw, rd);
        n_checks++; if (gw != 1)       begin n_fails++; $display("FAIL oor_gnt_wait: got %0d required 1", gw); end
        n_checks++; if (rw != 2)       begin n_fails++; $display("FAIL oor_rsp_wait: got %0d required 2", rw); end
        n_checks++; if (rd !== 32'h0)  begin n_fails++; $display("FAIL oor_rdata: got %h required 0", rd); end
        txn(0, 1, 1'b1, 7'd120, 32'hFFFFFFFF, 4'hF, gw, rw, rd);
        txn(0, 1, 1'b0, 7'd20, 32'h0, 4'h0, gw, rw, rd);
        n_checks++; if (rd !== 32'h0BADF00D) begin n_fails++; $display("FAIL oor_no_alias: got %h required 0badf00d", rd); end
    endtask

    task automatic test_back_to_back();
        int g_cyc[$];
        int v_cyc[$];
        int early;
        logic [1:0] occ2, occ8, occ10;
        early = 0; occ2 = '0; occ8 = '0; occ10 = '0;
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 7'd3, 32'h0, 4'h0);
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (f_gnt) begin g_cyc.push_back(c); if (c < 6) early++; end
            if (f_rvalid) v_cyc.push_back(c);
            if (c == 2)  occ2  = f_outstanding;
            if (c == 8)  occ8  = f_outstanding;
            if (c == 10) occ10 = f_outstanding;
            @(posedge clk); #1;
            if (g_cyc.size() >= 3) f_req = 1'b0;
        end
        n_checks++; if (early != 2)         begin n_fails++; $display("FAIL b2b_grants_first6: got %0d required 2", early); end
        n_checks++; if (g_cyc.size() != 3)  begin n_fails++; $display("FAIL b2b_grant_count: got %0d required 3", g_cyc.size()); end
        n_checks++; if (g_cyc[0] != 0)      begin n_fails++; $display("FAIL b2b_first_grant: got cycle %0d required 0", g_cyc[0]); end
        n_checks++; if (g_cyc[2] != 9)      begin n_fails++; $display("FAIL b2b_third_grant: got cycle %0d required 9", g_cyc[2]); end
        n_checks++; if (v_cyc.size() != 3)  begin n_fails++; $display("FAIL b2b_rvalid_count: got %0d required 3", v_cyc.size()); end
        n_checks++; if (v_cyc[0] != 8)      begin n_fails++; $display("FAIL b2b_rvalid0: got cycle %0d required 8", v_cyc[0]); end
        n_checks++; if (v_cyc[1] != 9)      begin n_fails++; $display("FAIL b2b_rvalid1: got cycle %0d required 9", v_cyc[1]); end
        n_checks++; if (v_cyc[2] != 17)     begin n_fails++; $display("FAIL b2b_rvalid2: got cycle %0d required 17", v_cyc[2]); end
        n_checks++; if (occ2 != 2'd2)       begin n_fails++; $display("FAIL b2b_occ_c2: got %0d required 2", occ2); end
        n_checks++; if (occ8 != 2'd2)       begin n_fails++; $display("FAIL b2b_occ_c8: got %0d required 2", occ8); end
        n_checks++; if (occ10 != 2'd1)      begin n_fails++; $display("FAIL b2b_occ_pushpop: got %0d required 1", occ10); end
    endtask

    task automatic test_reset_pending();
        int gw, rw, n_late;
        logic [31:0] rd;
        n_late = 0;
        txn(1, 3, 1'b1, 7'd7, 32'hCAFEF00D, 4'hF, gw, rw, rd);
        n_checks++; if (gw != 0)   begin n_fails++; $display("FAIL rp_comb_gnt_wait: got %0d required 0", gw); end
        n_checks++; if (rw != 8)   begin n_fails++; $display("FAIL rp_rsp_wait: got %0d required 8", rw); end
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 7'd7, 32'h0, 4'h0);
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        f_req = 1'b0;
        repeat (6) @(negedge clk);
        n_checks++; if (r_outstanding !== 3'd3) begin n_fails++; $display("FAIL rp_pending: got %0d required 3", r_outstanding); end
        n_checks++; if (r_rvalid !== 1'b1)      begin n_fails++; $display("FAIL rp_rvalid_before: got %b required 1", r_rvalid); end
        n_checks++; if (r_rdata !== 32'hCAFEF00D) begin n_fails++; $display("FAIL rp_rdata_before: got %h required cafef00d", r_rdata); end
        rst = 1'b1;
        #1;
        n_checks++; if (r_rvalid !== 1'b0)      begin n_fails++; $display("FAIL rp_rvalid_async: got %b required 0", r_rvalid); end
        n_checks++; if (r_rdata !== 32'h0)      begin n_fails++; $display("FAIL rp_rdata_async: got %h required 0", r_rdata); end
        n_checks++; if (r_outstanding !== 3'd0) begin n_fails++; $display("FAIL rp_outstanding_async: got %0d required 0", r_outstanding); end
        n_checks++; if (r_gnt !== 1'b0)         begin n_fails++; $display("FAIL rp_gnt_async: got %b required 0", r_gnt); end
        @(negedge clk);
        rst = 1'b0;
        repeat (16) begin
            @(negedge clk);
            if (r_rvalid) n_late++;
        end
        n_checks++; if (n_late != 0) begin n_fails++; $display("FAIL rp_dropped: got %0d rvalid pulses required 0", n_late); end
        txn(1, 3, 1'b0, 7'd7, 32'h0, 4'h0, gw, rw, rd);
        n_checks++; if (rd !== 32'hCAFEF00D) begin n_fails++; $display("FAIL rp_mem_retained: got %h required cafef00d", rd); end
    endtask
`endif

    initial begin
        test_reset();
`ifdef OBI_DELAY_MEMORY_LFSR_STALL_EN
        test_lfsr();
`else
        test_write_read();
        test_byte_enable();
        test_out_of_range();
        test_back_to_back();
        test_reset_pending();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
